gbf_stream_loader: RTL and testbench

- Upstream fill stage for one operand double-buffer (actv or wgt) of accelerator_w_o_sram; instantiated twice, once per operand.
- Accepts a valid/ready word stream and writes it into GBF buffer 1 / buffer 2 through the a-side write ports.
- Serves fills in strict ping-pong order, gated by the controller's need_data requests.
- Drives the per-buffer ready, data_avail and finish signals.

---
 rtl/gbf_stream_loader_pkg.sv | 30 +++
 rtl/gbf_stream_loader_if.sv | 15 +
 rtl/gbf_write_port_reg.sv | 55 +++++
 rtl/gbf_stream_loader.sv | 161 ++++++++++++++++
 tb/tb_gbf_stream_loader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gbf_stream_loader_pkg.sv
// Shared definitions for the GBF fill/drain blocks: state encoding, default
// widths and the fill-length clamp.
package gbf_stream_loader_pkg;

    localparam int DEF_DATA_BITWIDTH     = 256;
    localparam int DEF_ADDR_BITWIDTH     = 5;
    localparam int DEF_DEPTH             = 32;
    localparam int DEF_TILE_CNT_BITWIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_FILL,
        ST_COMMIT,
        ST_DONE
    } load_state_t;

    // Zero-length fills become one word; oversize fills stop at the buffer depth.
    function automatic int unsigned clamp_fill_len(input int unsigned len,
                                                   input int unsigned depth);
        if (len == 0) begin
            return 1;
        end
        if (len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage

// File: rtl/gbf_stream_loader_if.sv
// Valid/ready word stream feeding a GBF loader.
interface gbf_stream_loader_if
    import gbf_stream_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_BITWIDTH
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/gbf_write_port_reg.sv
// Registered write strobe stage: one accepted beat becomes a single-cycle
// en/we/addr/w_data pulse on the selected buffer's a-side port.
module gbf_write_port_reg #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              en1a,
    output logic              we1a,
    output logic [ADDR_W-1:0] addr1a,
    output logic [DATA_W-1:0] w_data1a,
    output logic              en2a,
    output logic              we2a,
    output logic [ADDR_W-1:0] addr2a,
    output logic [DATA_W-1:0] w_data2a
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              en_reg;
        logic [ADDR_W-1:0] addr_reg;
        logic [DATA_W-1:0] data_reg;
        logic              hit;

        assign hit = wr_valid && (wr_sel == 1'(gi));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                en_reg   <= 1'b0;
                addr_reg <= '0;
                data_reg <= '0;
            end else begin
                en_reg <= hit;
                if (hit) begin
                    addr_reg <= wr_addr;
                    data_reg <= wr_data;
                end
            end
        end
    end

    assign en1a     = g_port[0].en_reg;
    assign we1a     = g_port[0].en_reg;
    assign addr1a   = g_port[0].addr_reg;
    assign w_data1a = g_port[0].data_reg;
    assign en2a     = g_port[1].en_reg;
    assign we2a     = g_port[1].en_reg;
    assign addr2a   = g_port[1].addr_reg;
    assign w_data2a = g_port[1].data_reg;

endmodule

// File: rtl/gbf_stream_loader.sv
// Fills one operand's GBF double buffer from a word stream, alternating
// buffer 1 / buffer 2 on the controller's need_data requests.
module gbf_stream_loader
    import gbf_stream_loader_pkg::*;
#(
    parameter int GBF_DATA_BITWIDTH = DEF_DATA_BITWIDTH,
    parameter int GBF_ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
    parameter int GBF_DEPTH         = DEF_DEPTH,
    parameter int TILE_CNT_BITWIDTH = DEF_TILE_CNT_BITWIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [GBF_ADDR_BITWIDTH:0]   cfg_fill_len,
    input  logic [TILE_CNT_BITWIDTH-1:0] cfg_num_tiles,
    gbf_stream_loader_if.slave           stream,
    input  logic                         gbf1_need_data,
    input  logic                         gbf2_need_data,
    output logic                         en1a,
    output logic                         we1a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
    output logic                         en2a,
    output logic                         we2a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
    output logic                         gbf_buf1_ready,
    output logic                         gbf_buf2_ready,
    output logic                         gbf_data_avail,
    output logic                         finish
);

    localparam int FILL_W = GBF_ADDR_BITWIDTH + 1;

    load_state_t                  state_reg;
    load_state_t                  state_next;
    logic [FILL_W-1:0]            fill_len_reg;
    logic [FILL_W-1:0]            word_cnt_reg;
    logic [TILE_CNT_BITWIDTH-1:0] num_tiles_reg;
    logic [TILE_CNT_BITWIDTH-1:0] tile_cnt_reg;
    logic                         target_reg;     // 0 = buffer 1, 1 = buffer 2
    logic [1:0]                   buf_ready_reg;

    logic start_ok;
    logic target_need;
    logic accept;
    logic last_beat;
    logic last_tile;

    assign start_ok    = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign target_need = target_reg ? gbf2_need_data : gbf1_need_data;
    assign accept      = (state_reg == ST_FILL) && stream.in_valid;
    assign last_beat   = (word_cnt_reg == fill_len_reg - FILL_W'(1));
    assign last_tile   = ((tile_cnt_reg + TILE_CNT_BITWIDTH'(1)) == num_tiles_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_next = (cfg_num_tiles == '0) ? ST_DONE : ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (target_need) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept && last_beat) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_next = last_tile ? ST_DONE : ST_WAIT_REQ;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tiles remain exactly while a fill sequence is in flight.
    always_comb begin
        stream.in_ready = 1'b0;
        gbf_data_avail  = 1'b0;
        finish          = 1'b0;
        case (state_reg)
            ST_WAIT_REQ: gbf_data_avail = 1'b1;
            ST_FILL: begin
                gbf_data_avail  = 1'b1;
                stream.in_ready = 1'b1;
            end
            ST_COMMIT:   gbf_data_avail = 1'b1;
            ST_DONE:     finish = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_len_reg  <= '0;
            word_cnt_reg  <= '0;
            num_tiles_reg <= '0;
            tile_cnt_reg  <= '0;
            target_reg    <= 1'b0;
            buf_ready_reg <= '0;
        end else begin
            if (start_ok) begin
                fill_len_reg  <= FILL_W'(clamp_fill_len(32'(cfg_fill_len), GBF_DEPTH));
                num_tiles_reg <= cfg_num_tiles;
                tile_cnt_reg  <= '0;
                word_cnt_reg  <= '0;
                target_reg    <= 1'b0;
            end
            // A buffer stops being ready as soon as its refill begins.
            if (state_reg == ST_WAIT_REQ && target_need) begin
                buf_ready_reg[target_reg] <= 1'b0;
            end
            if (accept) begin
                word_cnt_reg <= word_cnt_reg + FILL_W'(1);
            end
            if (state_reg == ST_COMMIT) begin
                buf_ready_reg[target_reg] <= 1'b1;
                tile_cnt_reg              <= tile_cnt_reg + TILE_CNT_BITWIDTH'(1);
                word_cnt_reg              <= '0;
                target_reg                <= ~target_reg;
            end
        end
    end

    assign gbf_buf1_ready = buf_ready_reg[0];
    assign gbf_buf2_ready = buf_ready_reg[1];

    gbf_write_port_reg #(
        .DATA_W (GBF_DATA_BITWIDTH),
        .ADDR_W (GBF_ADDR_BITWIDTH)
    ) u_wport (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (accept),
        .wr_sel   (target_reg),
        .wr_addr  (word_cnt_reg[GBF_ADDR_BITWIDTH-1:0]),
        .wr_data  (stream.in_data),
        .en1a     (en1a),
        .we1a     (we1a),
        .addr1a   (addr1a),
        .w_data1a (w_data1a),
        .en2a     (en2a),
        .we2a     (we2a),
        .addr2a   (addr2a),
        .w_data2a (w_data2a)
    );

endmodule

// File: tb/tb_gbf_stream_loader.sv
// Scoreboard bench for gbf_stream_loader: expected writes are queued as beats
// are offered and matched against port strobes on the falling edge.
module tb_gbf_stream_loader;
    import gbf_stream_loader_pkg::*;

    localparam int DW    = 256;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int TW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   cfg_fill_len;
    logic [TW-1:0] cfg_num_tiles;
    logic          need1, need2;
    logic          en1a, we1a, en2a, we2a;
    logic [AW-1:0] addr1a, addr2a;
    logic [DW-1:0] w_data1a, w_data2a;
    logic          buf1_ready, buf2_ready, data_avail, finish;

    gbf_stream_loader_if #(.DATA_W(DW)) stream ();

    always #5 clk = ~clk;

    gbf_stream_loader #(
        .GBF_DATA_BITWIDTH (DW),
        .GBF_ADDR_BITWIDTH (AW),
        .GBF_DEPTH         (DEPTH),
        .TILE_CNT_BITWIDTH (TW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_fill_len   (cfg_fill_len),
        .cfg_num_tiles  (cfg_num_tiles),
        .stream         (stream),
        .gbf1_need_data (need1),
        .gbf2_need_data (need2),
        .en1a           (en1a),
        .we1a           (we1a),
        .addr1a         (addr1a),
        .w_data1a       (w_data1a),
        .en2a           (en2a),
        .we2a           (we2a),
        .addr2a         (addr2a),
        .w_data2a       (w_data2a),
        .gbf_buf1_ready (buf1_ready),
        .gbf_buf2_ready (buf2_ready),
        .gbf_data_avail (data_avail),
        .finish         (finish)
    );

    typedef struct {
        int            port;
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  m_fill, m_word, m_tile;

    always @(negedge clk) begin : monitor
        wr_t           e;
        logic          en_v, we_v;
        logic [AW-1:0] a_v;
        logic [DW-1:0] d_v;
        if (reset === 1'b0) begin
            for (int p = 1; p <= 2; p++) begin
                en_v = (p == 1) ? en1a : en2a;
                we_v = (p == 1) ? we1a : we2a;
                a_v  = (p == 1) ? addr1a : addr2a;
                d_v  = (p == 1) ? w_data1a : w_data2a;
                if (en_v === 1'b1 || we_v === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_strobe: port %0d en %b we %b addr %0d, no write expected", p, en_v, we_v, a_v);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.port != p || e.addr != int'(a_v) || e.data !== d_v || en_v !== we_v) begin
                            errors++;
                            $display("FAIL write: got port %0d addr %0d data %0h en %b we %b, want port %0d addr %0d data %0h en=we=1",
                                     p, a_v, d_v, en_v, we_v, e.port, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int fill, input int tiles);
        cfg_fill_len  = (AW+1)'(fill);
        cfg_num_tiles = TW'(tiles);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        m_fill = (fill == 0) ? 1 : ((fill > DEPTH) ? DEPTH : fill);
        m_word = 0;
        m_tile = 0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int  n;
        wr_t e;
        stream.in_valid = 1'b1;
        stream.in_data  = d;
        n = 0;
        while (stream.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready %b after %0d cycles, want 1", stream.in_ready, n);
            stream.in_valid = 1'b0;
            return;
        end
        e.port = (m_tile % 2 == 0) ? 1 : 2;
        e.addr = m_word;
        e.data = d;
        exp_q.push_back(e);
        m_word++;
        if (m_word == m_fill) begin
            m_word = 0;
            m_tile++;
        end
        @(posedge clk);
        #1;
        stream.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [8:0] flags;
        reset = 1'b1;
        tick(2);
        flags = {stream.in_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail, finish};
        checks++;
        if (flags !== 9'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000000", flags);
        end
        checks++;
        if ({addr1a, addr2a} !== '0 || w_data1a !== '0 || w_data2a !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr1 %0d addr2 %0d, want 0 with zero data", addr1a, addr2a);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        need1 = 1'b1;
        need2 = 1'b1;
        do_start(4, 2);
        checks++;
        if (data_avail !== 1'b1 || finish !== 1'b0) begin
            errors++;
            $display("FAIL basic_start: got data_avail %b finish %b want 1 0", data_avail, finish);
        end
        for (int i = 0; i < 8; i++) begin
            send(DW'(8'hA0 + i));
            if (i == 3) begin
                checks++;
                if (stream.in_ready !== 1'b0 || buf1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_commit: got in_ready %b buf1_ready %b want 0 0", stream.in_ready, buf1_ready);
                end
                tick(1);
                checks++;
                if (buf1_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_buf1_ready: got %b want 1", buf1_ready);
                end
            end
        end
        checks++;
        if (finish !== 1'b0 || data_avail !== 1'b1) begin
            errors++;
            $display("FAIL basic_last_commit: got finish %b data_avail %b want 0 1", finish, data_avail);
        end
        tick(1);
        checks++;
        if ({finish, data_avail, buf1_ready, buf2_ready} !== 4'b1011) begin
            errors++;
            $display("FAIL basic_done: got fin/avail/r1/r2 %b want 1011", {finish, data_avail, buf1_ready, buf2_ready});
        end
        tick(2);
    endtask

    task automatic test_need_gate;
        need1 = 1'b1;
        need2 = 1'b0;
        do_start(4, 2);
        for (int i = 0; i < 4; i++) send(DW'(8'hB0 + i));
        stream.in_valid = 1'b1;
        stream.in_data  = DW'(8'hEE);
        for (int c = 0; c < 10; c++) begin
            tick(1);
            checks++;
            if (stream.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL need_gate_cycle%0d: got in_ready %b want 0", c, stream.in_ready);
            end
        end
        stream.in_valid = 1'b0;
        need2 = 1'b1;
        for (int i = 4; i < 8; i++) send(DW'(8'hB0 + i));
        tick(1);
        checks++;
        if (finish !== 1'b1 || buf2_ready !== 1'b1) begin
            errors++;
            $display("FAIL need_gate_done: got finish %b buf2_ready %b want 1 1", finish, buf2_ready);
        end
        tick(2);
    endtask

    task automatic test_bubbles;
        need1 = 1'b1;
        do_start(3, 1);
        send(DW'(8'hC0));
        tick(1);
        send(DW'(8'hC1));
        tick(1);
        send(DW'(8'hC2));
        tick(1);
        checks++;
        if (finish !== 1'b1 || buf1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bubbles_done: got finish %b buf1_ready %b want 1 1", finish, buf1_ready);
        end
        tick(2);
    endtask

    task automatic test_reset_mid_fill;
        logic [4:0] flags;
        need1 = 1'b1;
        do_start(4, 1);
        send(DW'(8'hD0));
        stream.in_valid = 1'b1;
        stream.in_data  = DW'(8'hD1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        flags = {stream.in_ready, en1a, buf1_ready, buf2_ready, data_avail};
        checks++;
        if (flags !== 5'b0 || addr1a !== '0 || w_data1a !== '0) begin
            errors++;
            $display("FAIL async_reset: got rdy/en1/r1/r2/avail %b addr1 %0d want 00000 addr 0", flags, addr1a);
        end
        stream.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        tick(1);
        checks++;
        if (en1a !== 1'b0 || stream.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got en1a %b in_ready %b want 0 0", en1a, stream.in_ready);
        end
        do_start(4, 1);
        for (int i = 0; i < 4; i++) send(DW'(8'hD8 + i));
        tick(1);
        checks++;
        if (finish !== 1'b1 || buf1_ready !== 1'b1) begin
            errors++;
            $display("FAIL refill_done: got finish %b buf1_ready %b want 1 1", finish, buf1_ready);
        end
        tick(2);
    endtask

    task automatic test_zero_tiles;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL zero_pre: got finish %b want 0", finish);
        end
        do_start(4, 0);
        checks++;
        if (finish !== 1'b1 || data_avail !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got finish %b data_avail %b want 1 0", finish, data_avail);
        end
        stream.in_valid = 1'b1;
        stream.in_data  = DW'(8'h55);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (stream.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL zero_in_ready%0d: got %b want 0", c, stream.in_ready);
            end
            tick(1);
        end
        stream.in_valid = 1'b0;
    endtask

    task automatic test_clamp;
        need1 = 1'b1;
        do_start(40, 1);
        for (int i = 0; i < DEPTH; i++) send(DW'(16'h0E00 + i));
        checks++;
        if (stream.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clamp_commit: got in_ready %b want 0 after %0d words", stream.in_ready, DEPTH);
        end
        stream.in_valid = 1'b1;
        stream.in_data  = DW'(8'h77);
        tick(1);
        checks++;
        if (finish !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done: got finish %b want 1", finish);
        end
        tick(2);
        stream.in_valid = 1'b0;
        do_start(0, 1);
        send(DW'(8'hF0));
        checks++;
        if (stream.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_commit: got in_ready %b want 0 after one word", stream.in_ready);
        end
        tick(1);
        checks++;
        if (finish !== 1'b1) begin
            errors++;
            $display("FAIL len0_done: got finish %b want 1", finish);
        end
        tick(2);
    endtask

    task automatic test_three_tiles;
        need1 = 1'b1;
        need2 = 1'b1;
        do_start(2, 3);
        for (int i = 0; i < 4; i++) send(DW'(8'h30 + i));
        checks++;
        if (buf1_ready !== 1'b1) begin
            errors++;
            $display("FAIL three_r1_held: got %b want 1", buf1_ready);
        end
        tick(1);
        checks++;
        if (buf1_ready !== 1'b1 || buf2_ready !== 1'b1 || finish !== 1'b0) begin
            errors++;
            $display("FAIL three_after2: got r1 %b r2 %b finish %b want 1 1 0", buf1_ready, buf2_ready, finish);
        end
        tick(1);
        checks++;
        if (buf1_ready !== 1'b0 || stream.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL three_fill3_entry: got r1 %b in_ready %b want 0 1", buf1_ready, stream.in_ready);
        end
        for (int i = 4; i < 6; i++) send(DW'(8'h30 + i));
        tick(1);
        checks++;
        if (buf1_ready !== 1'b1 || finish !== 1'b1 || data_avail !== 1'b0) begin
            errors++;
            $display("FAIL three_done: got r1 %b finish %b avail %b want 1 1 0", buf1_ready, finish, data_avail);
        end
        tick(2);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        cfg_fill_len    = '0;
        cfg_num_tiles   = '0;
        need1           = 1'b0;
        need2           = 1'b0;
        stream.in_valid = 1'b0;
        stream.in_data  = '0;
        test_reset();
        test_basic();
        test_need_gate();
        test_bubbles();
        test_reset_mid_fill();
        test_zero_tiles();
        test_clamp();
        test_three_tiles();
        tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: got %0d unobserved writes want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
